// File: rtl/reg_file_pkg.sv
// Register file geometry and the address/data types shared with the decode and writeback stages.
package reg_file_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file.sv
// 16x16 register file: two combinational read ports, two synchronous write ports (port 2 wins on conflict).
// Latency: reads zero cycles; writes visible just after the writing edge, with no write-through bypass.
// Backpressure: none; every enabled write is accepted on its edge.
module reg_file
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      w_enable1,
  input  logic      w_enable2,
  input  reg_addr_t d1read,
  input  reg_addr_t d2read,
  input  reg_addr_t addr1,
  input  reg_addr_t addr2,
  input  reg_data_t d1writeback,
  input  reg_data_t d2writeback,
  output reg_data_t d1write,
  output reg_data_t d2write
);

  reg_data_t regs [DEPTH];

  // Per-register select; testing port 2 first gives it priority when both target the same entry.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst) begin
        regs[i] <= '0;
      end else if (w_enable2 && (addr2 == reg_addr_t'(i))) begin
        regs[i] <= d2writeback;
      end else if (w_enable1 && (addr1 == reg_addr_t'(i))) begin
        regs[i] <= d1writeback;
      end
    end
  end

  // Outputs are forced to zero during reset so they are defined before the first clearing edge.
  assign d1write = rst ? regs[d1read] : '0;
  assign d2write = rst ? regs[d2read] : '0;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed scenarios plus randomized traffic checked against an array model.
`timescale 1ns/1ps
module tb_reg_file;
  import reg_file_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  logic      w_enable1, w_enable2;
  reg_addr_t d1read, d2read, addr1, addr2;
  reg_data_t d1writeback, d2writeback;
  reg_data_t d1write, d2write;

  int n_cmp = 0;
  int n_bad = 0;
  reg_data_t model [DEPTH];

  reg_file dut (
    .clk         (clk),
    .rst         (rst),
    .w_enable1   (w_enable1),
    .w_enable2   (w_enable2),
    .d1read      (d1read),
    .d2read      (d2read),
    .addr1       (addr1),
    .addr2       (addr2),
    .d1writeback (d1writeback),
    .d2writeback (d2writeback),
    .d1write     (d1write),
    .d2write     (d2write)
  );

  always #50 clk = ~clk;

  task automatic chk(input string tag, input reg_data_t got, input reg_data_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One rising edge; the model applies the architectural write rules with the inputs held at that edge.
  task automatic step();
    @(posedge clk);
    if (rst !== 1'b1) begin
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
    end else begin
      if (w_enable1) model[addr1] = d1writeback;
      if (w_enable2) model[addr2] = d2writeback;
    end
    #1;
  endtask

  function automatic reg_data_t expect_rd(input reg_addr_t a);
    return (rst === 1'b1) ? model[a] : '0;
  endfunction

  task automatic check_reads(input string tag);
    #1;
    chk({tag, ".p1"}, d1write, expect_rd(d1read));
    chk({tag, ".p2"}, d2write, expect_rd(d2read));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      d1read = reg_addr_t'(i);
      d2read = reg_addr_t'(DEPTH - 1 - i);
      check_reads(tag);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    rst = 1'b0; w_enable1 = 1'b0; w_enable2 = 1'b0;
    addr1 = '0; addr2 = '0; d1writeback = '0; d2writeback = '0;
    d1read = 4'd3; d2read = 4'd12;

    // Outputs defined from time zero while reset is low
    #1;
    chk("t0.p1", d1write, 16'h0000);
    chk("t0.p2", d2write, 16'h0000);

    repeat (5) step();
    chk("rst.p1", d1write, 16'h0000);
    chk("rst.p2", d2write, 16'h0000);
    read_all("rst_all");

    // Dual write to distinct addresses
    d1read = 4'd3; d2read = 4'd12;
    rst = 1'b1;
    w_enable1 = 1'b1; addr1 = 4'd10; d1writeback = 16'h1A1A;
    w_enable2 = 1'b1; addr2 = 4'd12; d2writeback = 16'h2BC3;
    #1;
    chk("nobypass.p2", d2write, 16'h0000);
    step();
    chk("dual.p1", d1write, 16'h0000);
    chk("dual.p2", d2write, 16'h2BC3);
    d1read = 4'd10;
    #1;
    chk("dual.comb", d1write, 16'h1A1A);

    // Same-address conflict
    addr1 = 4'd5; d1writeback = 16'hAAAA;
    addr2 = 4'd5; d2writeback = 16'h5555;
    step();
    w_enable1 = 1'b0; w_enable2 = 1'b0;
    d1read = 4'd5; d2read = 4'd5;
    #1;
    chk("conflict.p1", d1write, 16'h5555);
    chk("conflict.p2", d2write, 16'h5555);

    // Enable gating, including unknown data with the enables low
    w_enable1 = 1'b1; addr1 = 4'd7; d1writeback = 16'h1234;
    step();
    w_enable1 = 1'b0; d1writeback = 16'hFFFF;
    w_enable2 = 1'b0; addr2 = 4'd7; d2writeback = 'x;
    repeat (3) step();
    d1read = 4'd7; d2read = 4'd7;
    #1;
    chk("gate.p1", d1write, 16'h1234);
    chk("gate.p2", d2write, 16'h1234);

    // Sweep through alternating ports
    for (int i = 0; i < DEPTH; i++) begin
      w_enable1 = (i % 2 == 0);
      w_enable2 = (i % 2 == 1);
      addr1 = reg_addr_t'(i); addr2 = reg_addr_t'(i);
      d1writeback = reg_data_t'(16'h1111 * i);
      d2writeback = reg_data_t'(16'h1111 * i);
      step();
    end
    w_enable1 = 1'b0; w_enable2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d1read = reg_addr_t'(i);
      d2read = reg_addr_t'(i);
      #1;
      chk("sweep.p1", d1write, reg_data_t'(16'h1111 * i));
      chk("sweep.p2", d2write, reg_data_t'(16'h1111 * i));
    end
    read_all("sweep_all");

    // Reset mid-operation with writes pending
    d1read = 4'd15; d2read = 4'd9;
    rst = 1'b0;
    w_enable1 = 1'b1; addr1 = 4'd1; d1writeback = 16'hBEEF;
    w_enable2 = 1'b1; addr2 = 4'd2; d2writeback = 16'hCAFE;
    #1;
    chk("midrst.p1", d1write, 16'h0000);
    chk("midrst.p2", d2write, 16'h0000);
    step();
    rst = 1'b1; w_enable1 = 1'b0; w_enable2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      d1read = reg_addr_t'(i);
      #1;
      chk("midrst.clear", d1write, 16'h0000);
    end

    // Randomized traffic, including occasional reset and forced address collisions
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 24) != 0);
      w_enable1 = 1'($urandom);
      w_enable2 = 1'($urandom);
      addr1 = reg_addr_t'($urandom);
      addr2 = ($urandom_range(0, 3) == 0) ? addr1 : reg_addr_t'($urandom);
      d1writeback = reg_data_t'($urandom);
      d2writeback = reg_data_t'($urandom);
      d1read = reg_addr_t'($urandom);
      d2read = ($urandom_range(0, 3) == 0) ? addr1 : reg_addr_t'($urandom);
      check_reads("rnd_pre");
      step();
      check_reads("rnd_post");
      d1read = reg_addr_t'($urandom);
      d2read = reg_addr_t'($urandom);
      check_reads("rnd_addr");
    end
    rst = 1'b1; w_enable1 = 1'b0; w_enable2 = 1'b0;
    #1;
    read_all("final_all");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 16-entry x 16-bit general-purpose register file for the 16-bit pipelined CPU datapath.
- Two asynchronous read ports feed the decode/operand stage.
- Two synchronous write ports take writeback results (e.g. ALU result plus a second writeback such as multiply high half or load).

Parameters:
- DATA_W, 16, width of each register and of the data ports.
- ADDR_W, 4, register address width.
- DEPTH, 2**ADDR_W (16), number of registers (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset; registers clear on a clk edge while low.
- w_enable1  input  1  write enable, write port 1.
- w_enable2  input  1  write enable, write port 2.
- d1read  input  ADDR_W  read address, read port 1.
- d2read  input  ADDR_W  read address, read port 2.
- addr1  input  ADDR_W  write address, write port 1.
- addr2  input  ADDR_W  write address, write port 2.
- d1writeback  input  DATA_W  write data, port 1.
- d2writeback  input  DATA_W  write data, port 2.
- d1write  output  DATA_W  read data, port 1 (register selected by d1read).
- d2write  output  DATA_W  read data, port 2 (register selected by d2read).

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-low.
- Reset: on any rising clk edge with rst=0, all 16 registers become 16'h0000 and writes are ignored.
  - While rst=0, d1write and d2write are forced to 16'h0000 combinationally, so outputs are defined from time 0.
- Write timing: on a rising clk edge with rst=1:
  - if w_enable1=1, reg[addr1] <= d1writeback;
  - if w_enable2=1, reg[addr2] <= d2writeback.
- Both writes may occur in the same cycle to different addresses.
- Write conflict: addr1==addr2 with both enables high -> port 2 wins; reg gets d2writeback.
- Enables low: the register is unchanged regardless of address/data (including X on data).
- Read: combinational (zero latency).
  - d1write = reg[d1read], d2write = reg[d2read].
  - Outputs update as soon as the read address changes.
- No write-through bypass: a value written at edge N is visible on the outputs just after edge N (array update), not before the edge.
- Both read ports may address the same register, including a register being written.
- All 16 registers, including register 0, are ordinary writable storage; no hardwired zero.
- No X propagation from unwritten data: every register holds a defined value after the first reset edge.

Decomposition:
- Package reg_file_pkg: DATA_W, ADDR_W and DEPTH constants; typedefs reg_addr_t (logic [ADDR_W-1:0]) and reg_data_t (logic [DATA_W-1:0]), shared with decode and writeback stages.
- No sub-module needed. The storage array, per-register write-select logic (port-2 priority) and two read muxes fit in a single module.

Test Plan:
- Reset: rst=0 for 5 clk edges, d1read=3, d2read=12 -> d1write=16'h0000, d2write=16'h0000; all 16 registers read back 0.
- Dual write:
  - Release rst=1, w_enable1=w_enable2=1, addr1=10, d1writeback=16'h1A1A, addr2=12, d2writeback=16'h2BC3, d1read=3, d2read=12.
  - After next edge: d2write=16'h2BC3, d1write=16'h0000.
  - Then set d1read=10 -> d1write=16'h1A1A immediately, no clock needed.
- Write conflict: addr1=addr2=5, data 16'hAAAA / 16'h5555, both enabled -> reg5 reads 16'h5555.
- Enable gating: write 16'h1234 to reg7, then w_enable1=0 with addr1=7, d1writeback=16'hFFFF for 3 edges -> reg7 still 16'h1234.
- Reset mid-operation: registers loaded with nonzero values, rst=0 for one edge with enables high -> outputs 0 during reset; after release every register reads 16'h0000 and the write in the reset cycle is lost.
- Sweep: write reg[i]=16'h1111*i (i=0..15) through alternating ports, read back all 16 on both read ports -> exact match.
